// File: rtl/tama_pkg.sv
// Shared constants for the pet input front end: test-hold FSM encoding,
// edge-select codes and the ms-to-cycles helper.
package tama_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLDING = 2'd1;
  localparam logic [1:0] ST_FIRED   = 2'd2;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  function automatic int msToCycles(input int clkFreq, input int ms);
    return clkFreq / 1000 * ms;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// One input channel: synchroniser, optional inversion, stable-time debounce
// and a registered one-shot on the selected edge of the debounced level.
module input_debounce
  import tama_pkg::*;
#(
  parameter int   DB_CYC      = 4,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1,
  parameter logic INVERT      = 1'b1,
  parameter logic EDGE        = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic evt_pulse
);

  localparam int             CW         = $clog2(DB_CYC) + 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DB_CYC - 1);
  localparam logic           STABLE_RST = RST_VAL ^ INVERT;

  logic [SYNC_STAGES-1:0] syncQ;
  logic [CW-1:0]          cnt;
  logic                   synced;
  logic                   stableQ;
  logic                   edgeSeen;

  assign synced   = syncQ[SYNC_STAGES-1] ^ INVERT;
  assign edgeSeen = (EDGE == EDGE_RISE) ? (stable & ~stableQ) : (~stable & stableQ);

  // Any sample that agrees with the stable level restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncQ     <= {SYNC_STAGES{RST_VAL}};
      cnt       <= '0;
      stable    <= STABLE_RST;
      stableQ   <= STABLE_RST;
      evt_pulse <= 1'b0;
    end else begin
      syncQ     <= {syncQ[SYNC_STAGES-2:0], raw};
      stableQ   <= stable;
      evt_pulse <= edgeSeen;
      if (synced != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= synced;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/tama_input_conditioner.sv
// Conditions the raw buttons and sensors into single-cycle events for the pet
// FSM; the test button only reports a long press.
//
//   state      | meaning
//   ST_IDLE    | test button released, waiting for a debounced press
//   ST_HOLDING | test button pressed, counting toward the hold time
//   ST_FIRED   | hold time reached and pulse sent, waiting for release
module tama_input_conditioner
  import tama_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 3000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_feed_n,
  input  logic btn_heal_n,
  input  logic btn_mode_n,
  input  logic btn_test_n,
  input  logic light_raw,
  input  logic echo_raw,
  output logic feed_pulse,
  output logic heal_pulse,
  output logic mode_pulse,
  output logic test_pulse,
  output logic light_out_pulse,
  output logic echo_pulse,
  output logic light_dark
);

  localparam int            DB_CYC    = msToCycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int            HOLD_CYC  = msToCycles(CLK_FREQ, HOLD_MS);
  localparam int            HW        = $clog2(HOLD_CYC) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  logic feedStableUnused;
  logic healStableUnused;
  logic modeStableUnused;
  logic echoStableUnused;
  logic testEvtUnused;
  logic testPressed;
  logic lightLevel;

  input_debounce #(.DB_CYC(DB_CYC), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1),
                   .INVERT(1'b1), .EDGE(EDGE_RISE))
  uFeed (.clk(clk), .rst(rst), .raw(btn_feed_n), .stable(feedStableUnused), .evt_pulse(feed_pulse));

  input_debounce #(.DB_CYC(DB_CYC), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1),
                   .INVERT(1'b1), .EDGE(EDGE_RISE))
  uHeal (.clk(clk), .rst(rst), .raw(btn_heal_n), .stable(healStableUnused), .evt_pulse(heal_pulse));

  input_debounce #(.DB_CYC(DB_CYC), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1),
                   .INVERT(1'b1), .EDGE(EDGE_RISE))
  uMode (.clk(clk), .rst(rst), .raw(btn_mode_n), .stable(modeStableUnused), .evt_pulse(mode_pulse));

  input_debounce #(.DB_CYC(DB_CYC), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1),
                   .INVERT(1'b1), .EDGE(EDGE_RISE))
  uTest (.clk(clk), .rst(rst), .raw(btn_test_n), .stable(testPressed), .evt_pulse(testEvtUnused));

  // Light event is the onset of darkness, i.e. the falling edge of the light level.
  input_debounce #(.DB_CYC(DB_CYC), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1),
                   .INVERT(1'b0), .EDGE(EDGE_FALL))
  uLight (.clk(clk), .rst(rst), .raw(light_raw), .stable(lightLevel), .evt_pulse(light_out_pulse));

  input_debounce #(.DB_CYC(DB_CYC), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0),
                   .INVERT(1'b0), .EDGE(EDGE_RISE))
  uEcho (.clk(clk), .rst(rst), .raw(echo_raw), .stable(echoStableUnused), .evt_pulse(echo_pulse));

  logic [1:0]    testState;
  logic [HW-1:0] hcnt;
  logic          testPulseQ;
  logic          lightDarkQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      testState  <= ST_IDLE;
      hcnt       <= '0;
      testPulseQ <= 1'b0;
    end else begin
      testPulseQ <= 1'b0;
      case (testState)
        ST_IDLE: begin
          if (testPressed) begin
            testState <= ST_HOLDING;
            hcnt      <= '0;
          end
        end
        ST_HOLDING: begin
          if (!testPressed) begin
            testState <= ST_IDLE;
          end else if (hcnt == HOLD_LAST) begin
            testState  <= ST_FIRED;
            testPulseQ <= 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_FIRED: begin
          if (!testPressed) testState <= ST_IDLE;
        end
        default: testState <= ST_IDLE;
      endcase
    end
  end

  // Registered so the dark level moves in the same cycle as light_out_pulse.
  always_ff @(posedge clk) begin
    if (rst) lightDarkQ <= 1'b0;
    else     lightDarkQ <= ~lightLevel;
  end

  assign test_pulse = testPulseQ;
  assign light_dark = lightDarkQ;

endmodule

// File: tb/tb_tama_input_conditioner.sv
// Scoreboard bench: expected pulses are queued with their due cycle when
// stimulus is driven, and every output is compared each cycle.
module tb_tama_input_conditioner;

  localparam int CLK_FREQ    = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int HOLD_MS     = 20;
  localparam int SYNC_STAGES = 2;

  localparam logic [5:0] P_FEED = 6'b100000;
  localparam logic [5:0] P_HEAL = 6'b010000;
  localparam logic [5:0] P_MODE = 6'b001000;
  localparam logic [5:0] P_TEST = 6'b000100;
  localparam logic [5:0] P_LOUT = 6'b000010;
  localparam logic [5:0] P_ECHO = 6'b000001;

  typedef struct {
    int         cycle;
    logic [5:0] pulses;
    logic       setDark;
    logic       dark;
  } expItem_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_feed_n, btn_heal_n, btn_mode_n, btn_test_n, light_raw, echo_raw;
  logic feed_pulse, heal_pulse, mode_pulse, test_pulse, light_out_pulse, echo_pulse, light_dark;

  expItem_t   sbQ[$];
  expItem_t   popItem;
  logic [5:0] expPulses;
  logic       darkExp = 1'b0;
  bit         monOn = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  tama_input_conditioner #(
    .CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS), .HOLD_MS(HOLD_MS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_feed_n(btn_feed_n), .btn_heal_n(btn_heal_n), .btn_mode_n(btn_mode_n),
    .btn_test_n(btn_test_n), .light_raw(light_raw), .echo_raw(echo_raw),
    .feed_pulse(feed_pulse), .heal_pulse(heal_pulse), .mode_pulse(mode_pulse),
    .test_pulse(test_pulse), .light_out_pulse(light_out_pulse), .echo_pulse(echo_pulse),
    .light_dark(light_dark)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkIt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the n-th following rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectAt(input int offset, input logic [5:0] pulses, input logic setDark,
                          input logic dark);
    expItem_t it;
    it.cycle   = cyc + offset;
    it.pulses  = pulses;
    it.setDark = setDark;
    it.dark    = dark;
    sbQ.push_back(it);
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      expPulses = '0;
      while (sbQ.size() > 0 && sbQ[0].cycle <= cyc) begin
        popItem = sbQ.pop_front();
        checkIt("due_cycle", popItem.cycle, cyc);
        expPulses |= popItem.pulses;
        if (popItem.setDark) darkExp = popItem.dark;
      end
      checkIt("outs",
              {feed_pulse, heal_pulse, mode_pulse, test_pulse, light_out_pulse, echo_pulse, light_dark},
              {expPulses, darkExp});
    end
  end

  initial begin
    rst = 1'b1;
    btn_feed_n = 1'b1; btn_heal_n = 1'b1; btn_mode_n = 1'b1; btn_test_n = 1'b1;
    light_raw = 1'b1; echo_raw = 1'b0;
    tick(1);
    checkIt("rst_state",
            {feed_pulse, heal_pulse, mode_pulse, test_pulse, light_out_pulse, echo_pulse, light_dark},
            7'b0);
    monOn = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);

    // clean feed press and release
    btn_feed_n = 1'b0;
    expectAt(7, P_FEED, 1'b0, 1'b0);
    tick(12);
    btn_feed_n = 1'b1;
    tick(12);

    // bouncing heal press: only the final steady low counts
    btn_heal_n = 1'b0; tick(2);
    btn_heal_n = 1'b1; tick(1);
    btn_heal_n = 1'b0; tick(3);
    btn_heal_n = 1'b1; tick(1);
    btn_heal_n = 1'b0;
    expectAt(7, P_HEAL, 1'b0, 1'b0);
    tick(12);
    btn_heal_n = 1'b1;
    tick(12);

    // long test press fires once; short press never fires
    btn_test_n = 1'b0;
    expectAt(27, P_TEST, 1'b0, 1'b0);
    tick(30);
    btn_test_n = 1'b1;
    tick(12);
    btn_test_n = 1'b0;
    tick(15);
    btn_test_n = 1'b1;
    tick(30);

    // simultaneous light-out, echo and mode
    light_raw = 1'b0; echo_raw = 1'b1; btn_mode_n = 1'b0;
    expectAt(7, P_LOUT | P_ECHO | P_MODE, 1'b1, 1'b1);
    tick(12);
    light_raw = 1'b1; echo_raw = 1'b0; btn_mode_n = 1'b1;
    expectAt(7, 6'b0, 1'b1, 1'b0);
    tick(12);

    // reset mid-debounce with feed held
    btn_feed_n = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    expectAt(7, P_FEED, 1'b0, 1'b0);
    tick(12);
    btn_feed_n = 1'b1;
    tick(12);

    checkIt("sb_empty", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
